// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: bus bundle between IF/ID, the decode stage and EXE.
//   Upstream side : in_valid / in_ready / instruction, hazard_detected, flush
//   Writeback side: wb_write_en / wb_dest / wb_data
//   Downstream    : out_valid / out_ready plus the registered ID/EX fields
//   Status        : stall_cycles (saturating hazard-stall count)
// Modports: slave = decode stage view, master = surrounding pipeline view.
interface id_stage_pipe_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int STALL_W  = 16
);
  localparam int RADDR_W = $clog2(NUM_REGS);

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        instruction;
  logic               hazard_detected;
  logic               flush;
  logic               wb_write_en;
  logic [RADDR_W-1:0] wb_dest;
  logic [XLEN-1:0]    wb_data;
  logic               out_valid;
  logic               out_ready;
  logic [RADDR_W-1:0] dest, src1, src2;
  logic [XLEN-1:0]    val1, val2, reg2;
  logic [3:0]         exe_cmd;
  logic [1:0]         br_type;
  logic               mem_r_en, mem_w_en, wb_en, single_src, if_store_bne;
  logic [STALL_W-1:0] stall_cycles;

  modport slave (
    input  in_valid, instruction, hazard_detected, flush,
           wb_write_en, wb_dest, wb_data, out_ready,
    output in_ready, out_valid, dest, src1, src2, val1, val2, reg2,
           exe_cmd, br_type, mem_r_en, mem_w_en, wb_en, single_src,
           if_store_bne, stall_cycles
  );

  modport master (
    output in_valid, instruction, hazard_detected, flush,
           wb_write_en, wb_dest, wb_data, out_ready,
    input  in_ready, out_valid, dest, src1, src2, val1, val2, reg2,
           exe_cmd, br_type, mem_r_en, mem_w_en, wb_en, single_src,
           if_store_bne, stall_cycles
  );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with integrated ID/EX register and valid/ready.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (clears outputs, counter, regfile)
//   bus  : id_stage_pipe_if.slave (handshake, writeback port, ID/EX fields)
// Optional feature: define ID_WB_BYPASS_EN to forward a same-cycle
// writeback into the operand read (index 0 still reads 0).
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int STALL_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  id_stage_pipe_if.slave  bus
);
  localparam int RADDR_W = $clog2(NUM_REGS);

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic [1:0] br_type;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       single_src;
    logic       if_store_bne;
  } ctrl_t;

  logic [XLEN-1:0]    r_rf [NUM_REGS];
  logic               r_vld;
  ctrl_t              r_ctrl;
  logic [RADDR_W-1:0] r_dest, r_src1, r_src2;
  logic [XLEN-1:0]    r_val1, r_val2, r_reg2;
  logic [STALL_W-1:0] r_stall;

  logic [5:0]         w_op;
  logic [RADDR_W-1:0] w_rs, w_rt, w_rd;
  logic               w_is_imm;
  ctrl_t              w_ctrl;
  logic [XLEN-1:0]    w_rs_val, w_rt_val, w_sext;
  logic               w_ld;

  assign w_op   = bus.instruction[31:26];
  assign w_rs   = bus.instruction[21 +: RADDR_W];
  assign w_rt   = bus.instruction[16 +: RADDR_W];
  assign w_rd   = bus.instruction[11 +: RADDR_W];
  assign w_sext = XLEN'($signed(bus.instruction[15:0]));

  // Control unit: opcode -> execute command and side-band control bits.
  always_comb begin
    w_ctrl   = '0;
    w_is_imm = 1'b0;
    case (w_op)
      6'd1:  begin w_ctrl.exe_cmd = 4'b0000; w_ctrl.wb_en = 1'b1; end // ADD
      6'd3:  begin w_ctrl.exe_cmd = 4'b0010; w_ctrl.wb_en = 1'b1; end // SUB
      6'd5:  begin w_ctrl.exe_cmd = 4'b0100; w_ctrl.wb_en = 1'b1; end // AND
      6'd6:  begin w_ctrl.exe_cmd = 4'b0101; w_ctrl.wb_en = 1'b1; end // OR
      6'd7:  begin w_ctrl.exe_cmd = 4'b0110; w_ctrl.wb_en = 1'b1; end // NOR
      6'd8:  begin w_ctrl.exe_cmd = 4'b0111; w_ctrl.wb_en = 1'b1; end // XOR
      6'd9,
      6'd10: begin w_ctrl.exe_cmd = 4'b1000; w_ctrl.wb_en = 1'b1; end // SLA/SLL
      6'd11: begin w_ctrl.exe_cmd = 4'b1001; w_ctrl.wb_en = 1'b1; end // SRA
      6'd12: begin w_ctrl.exe_cmd = 4'b1010; w_ctrl.wb_en = 1'b1; end // SRL
      6'd32: begin w_ctrl.exe_cmd = 4'b0000; w_ctrl.wb_en = 1'b1; w_is_imm = 1'b1; end // ADDI
      6'd33: begin w_ctrl.exe_cmd = 4'b0010; w_ctrl.wb_en = 1'b1; w_is_imm = 1'b1; end // SUBI
      6'd36: begin // LD
        w_ctrl.mem_r_en = 1'b1; w_ctrl.wb_en = 1'b1; w_is_imm = 1'b1;
      end
      6'd37: begin // ST: rt carries the store data
        w_ctrl.mem_w_en = 1'b1; w_ctrl.if_store_bne = 1'b1; w_is_imm = 1'b1;
      end
      6'd40: begin w_ctrl.br_type = 2'b01; w_ctrl.single_src = 1'b1; w_is_imm = 1'b1; end // BEZ
      6'd41: begin w_ctrl.br_type = 2'b10; w_ctrl.if_store_bne = 1'b1; w_is_imm = 1'b1; end // BNE
      6'd42: begin w_ctrl.br_type = 2'b11; w_ctrl.single_src = 1'b1; w_is_imm = 1'b1; end // JMP
      default: ;
    endcase
  end

  // Operand read. r0 is forced to 0 even though writes to it are dropped,
  // so the bypass path can never leak wb_data for index 0.
`ifdef ID_WB_BYPASS_EN
  assign w_rs_val = (w_rs == '0) ? '0 :
                    (bus.wb_write_en && bus.wb_dest == w_rs) ? bus.wb_data : r_rf[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 :
                    (bus.wb_write_en && bus.wb_dest == w_rt) ? bus.wb_data : r_rf[w_rt];
`else
  assign w_rs_val = (w_rs == '0) ? '0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 : r_rf[w_rt];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else if (bus.wb_write_en && bus.wb_dest != '0) begin
      r_rf[bus.wb_dest] <= bus.wb_data;
    end
  end

  assign w_ld         = !r_vld || bus.out_ready;
  assign bus.in_ready = w_ld && !bus.hazard_detected && !bus.flush;

  // ID/EX register. Flush beats everything, including the stall count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld   <= 1'b0;
      r_ctrl  <= '0;
      r_dest  <= '0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_val1  <= '0;
      r_val2  <= '0;
      r_reg2  <= '0;
      r_stall <= '0;
    end else if (bus.flush) begin
      r_vld  <= 1'b0;
      r_ctrl <= '0;
    end else if (w_ld && bus.in_valid && bus.hazard_detected) begin
      r_vld  <= 1'b0;
      r_ctrl <= '0;
      if (r_stall != '1) r_stall <= r_stall + STALL_W'(1);
    end else if (w_ld && bus.in_valid) begin
      r_vld  <= 1'b1;
      r_ctrl <= w_ctrl;
      r_dest <= w_is_imm ? w_rt : w_rd;
      r_src1 <= w_rs;
      r_src2 <= w_is_imm ? '0 : w_rt;
      r_val1 <= w_rs_val;
      r_val2 <= w_is_imm ? w_sext : w_rt_val;
      r_reg2 <= w_rt_val;
    end else if (w_ld) begin
      r_vld <= 1'b0;
    end
  end

  assign bus.out_valid    = r_vld;
  assign bus.exe_cmd      = r_ctrl.exe_cmd;
  assign bus.br_type      = r_ctrl.br_type;
  assign bus.mem_r_en     = r_ctrl.mem_r_en;
  assign bus.mem_w_en     = r_ctrl.mem_w_en;
  assign bus.wb_en        = r_ctrl.wb_en;
  assign bus.single_src   = r_ctrl.single_src;
  assign bus.if_store_bne = r_ctrl.if_store_bne;
  assign bus.dest         = r_dest;
  assign bus.src1         = r_src1;
  assign bus.src2         = r_src2;
  assign bus.val1         = r_val1;
  assign bus.val2         = r_val2;
  assign bus.reg2         = r_reg2;
  assign bus.stall_cycles = r_stall;
endmodule
